// File: rtl/inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: accepts one ciphertext block, applies
// the initial AddRoundKey, then steps a shared inverse-round datapath once per
// cycle from round key Nr down to 0, and holds the plaintext until it is taken.
module inv_cipher_ctrl #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_block,
    output logic [3:0]   key_idx,
    input  logic [0:127] round_key,
    output logic [0:127] dp_state,
    output logic [0:127] dp_key,
    output logic         dp_final,
    input  logic [0:127] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_block,
    output logic         busy
);

    localparam int unsigned RND_W     = 4;
    localparam logic [RND_W-1:0] KEY_LAST  = RND_W'(Nr);
    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(Nr - 1);
    localparam bit          CFG_OK    = (Nr == Nk + 6);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t             state;
    logic [0:127]       state_reg;
    logic [RND_W-1:0]   rnd;

    // The datapath sees the working state and the key store output directly;
    // the plaintext is simply the working state once DONE is reached.
    assign dp_state  = state_reg;
    assign dp_key    = round_key;
    assign out_block = state_reg;

    // Key length and round count must describe the same AES variant.
    a_cfg_legal: assert property (@(posedge clk) CFG_OK);

    // Sequencer: state, working block, round counter and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            state_reg <= '0;
            rnd       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dp_final  <= 1'b0;
            key_idx   <= KEY_LAST;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_block ^ round_key;
                        rnd       <= FIRST_RND;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        if (FIRST_RND == '0) begin
                            state    <= FINAL;
                            key_idx  <= '0;
                            dp_final <= 1'b1;
                        end else begin
                            state    <= ROUND;
                            key_idx  <= FIRST_RND;
                        end
                    end
                end
                ROUND: begin
                    state_reg <= dp_result;
                    rnd       <= rnd - RND_W'(1);
                    key_idx   <= rnd - RND_W'(1);
                    if (rnd == RND_W'(1)) begin
                        state    <= FINAL;
                        dp_final <= 1'b1;
                    end
                end
                FINAL: begin
                    state_reg <= dp_result;
                    state     <= DONE;
                    dp_final  <= 1'b0;
                    key_idx   <= '0;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    // Output held stable until taken; no new block in this cycle.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        key_idx   <= KEY_LAST;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: two instances (AES-128 and AES-256) driven by a
// behavioural key store and inverse-round datapath, checked against a
// whole-block AES decryption model and the FIPS-197 known answers.
module tb_inv_cipher_ctrl;

    localparam int NR0 = 10;
    localparam int NR1 = 14;
    localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;

    typedef logic [0:15][7:0] blk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         dp_final  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         busy      [2];
    logic [127:0] in_block  [2];
    logic [127:0] round_key [2];
    logic [127:0] dp_state  [2];
    logic [127:0] dp_key    [2];
    logic [127:0] dp_result [2];
    logic [127:0] out_block [2];
    logic [3:0]   key_idx   [2];

    logic [7:0]   sbox [256];
    logic [7:0]   isb  [256];
    logic [127:0] rk   [2][15];

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    inv_cipher_ctrl #(.Nk(4), .Nr(NR0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_block(in_block[0]),
        .key_idx(key_idx[0]), .round_key(round_key[0]),
        .dp_state(dp_state[0]), .dp_key(dp_key[0]), .dp_final(dp_final[0]),
        .dp_result(dp_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_block(out_block[0]),
        .busy(busy[0])
    );

    inv_cipher_ctrl #(.Nk(8), .Nr(NR1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_block(in_block[1]),
        .key_idx(key_idx[1]), .round_key(round_key[1]),
        .dp_state(dp_state[1]), .dp_key(dp_key[1]), .dp_final(dp_final[1]),
        .dp_result(dp_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_block(out_block[1]),
        .busy(busy[1])
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic blk_t inv_mix(input blk_t s);
        blk_t       o;
        logic [7:0] coef [4];
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                o[4*c+i] = 8'h00;
                for (int j = 0; j < 4; j++)
                    o[4*c+i] = o[4*c+i] ^ gmul(coef[(j - i + 4) % 4], s[4*c+j]);
            end
        end
        return o;
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s_in, input logic [127:0] k,
                                               input logic last);
        blk_t s;
        blk_t t;
        s = s_in;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = isb[s[4*((c - r + 4) % 4) + r]];
        t = t ^ k;
        if (!last) t = inv_mix(t);
        return t;
    endfunction

    // Whole-block AES decryption with the instance's expanded key.
    function automatic logic [127:0] ref_decrypt(input int u, input logic [127:0] ct);
        int           nr;
        logic [127:0] s;
        nr = (u == 0) ? NR0 : NR1;
        s  = ct ^ rk[u][nr];
        for (int r = nr - 1; r >= 0; r--)
            s = inv_round(s, rk[u][r], r == 0);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Key store and inverse-round datapath seen by each instance.
    assign round_key[0] = rk[0][key_idx[0]];
    assign round_key[1] = rk[1][key_idx[1]];
    assign dp_result[0] = inv_round(dp_state[0], dp_key[0], dp_final[0]);
    assign dp_result[1] = inv_round(dp_state[1], dp_key[1], dp_final[1]);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
            isb[s]  = 8'(x);
        end
    endtask

    task automatic expand_key(input int u, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++)
            rk[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_reset_outputs(input int u);
        int nr;
        nr = (u == 0) ? NR0 : NR1;
        check("rst_in_ready",  128'(in_ready[u]),  128'(1));
        check("rst_out_valid", 128'(out_valid[u]), 128'(0));
        check("rst_busy",      128'(busy[u]),      128'(0));
        check("rst_dp_final",  128'(dp_final[u]),  128'(0));
        check("rst_key_idx",   128'(key_idx[u]),   128'(nr));
        check("rst_out_block", out_block[u],       128'(0));
    endtask

    // Present one block in IDLE, follow it to DONE (bounded) and return the plaintext.
    task automatic transact(input int u, input logic [127:0] ct, input bit noise,
                            input bit trace, output logic [127:0] got);
        int nr;
        int lat;
        nr  = (u == 0) ? NR0 : NR1;
        lat = 0;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready[u]), 128'(1));
        check("idle_key_idx",  128'(key_idx[u]),  128'(nr));
        in_valid[u] = 1'b1;
        in_block[u] = ct;
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_block[u] = rand128();
        while (!out_valid[u] && lat < 4 * nr) begin
            if (trace) begin
                check("trace_key_idx",  128'(key_idx[u]),  128'(nr - 1 - lat));
                check("trace_dp_final", 128'(dp_final[u]), 128'(lat == nr - 1));
                check("trace_busy",     128'(busy[u]),     128'(1));
                check("trace_in_ready", 128'(in_ready[u]), 128'(0));
            end
            if (noise) begin
                in_valid[u] = 1'($urandom);
                in_block[u] = rand128();
            end
            @(negedge clk);
            lat++;
        end
        in_valid[u] = 1'b0;
        check("latency",       128'(lat),         128'(nr));
        check("done_key_idx",  128'(key_idx[u]),  128'(0));
        check("done_in_ready", 128'(in_ready[u]), 128'(0));
        got = out_block[u];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [127:0] ct;
        logic [127:0] got;
        logic [127:0] cts [3];
        logic [127:0] outs [$];
        int           acc [3];
        int           nacc;
        int           cyc;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_block[u]  = '0;
            out_ready[u] = 1'b1;
        end
        build_sbox();
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR0);
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NR1);

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n = 1'b1;

        // Known answers, with per-cycle key index / final-round trace.
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        transact(0, ct, 1'b0, 1'b1, got);
        check("kat128", got, PT_KAT);
        check("kat128_model", got, ref_decrypt(0, ct));
        ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        transact(1, ct, 1'b0, 1'b1, got);
        check("kat256", got, PT_KAT);

        // Backpressure: output held for five cycles while input pulses are ignored.
        out_ready[0] = 1'b0;
        ct = rand128();
        transact(0, ct, 1'b0, 1'b0, got);
        check("bp_data", got, ref_decrypt(0, ct));
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_block[0] = rand128();
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid[0]), 128'(1));
            check("bp_out_block", out_block[0],       ref_decrypt(0, ct));
            check("bp_in_ready",  128'(in_ready[0]),  128'(0));
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
        check("bp_release_in_ready",  128'(in_ready[0]),  128'(1));
        check("bp_release_busy",      128'(busy[0]),      128'(0));

        // Back-to-back: in_valid and out_ready held high for three blocks.
        for (int i = 0; i < 3; i++) cts[i] = rand128();
        nacc = 0;
        cyc  = 0;
        while (outs.size() < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid[0]) outs.push_back(out_block[0]);
            if (nacc < 3) begin
                in_valid[0] = 1'b1;
                in_block[0] = cts[nacc];
            end else begin
                in_valid[0] = 1'b0;
            end
            if (in_ready[0] && in_valid[0]) begin
                acc[nacc] = cyc;
                nacc++;
            end
        end
        in_valid[0] = 1'b0;
        check("b2b_count", 128'(outs.size()), 128'(3));
        for (int i = 0; i < 3 && i < outs.size(); i++)
            check("b2b_data", outs[i], ref_decrypt(0, cts[i]));
        // Nr cycles to out_valid, one DONE cycle, one IDLE cycle before the next accept.
        if (nacc == 3) begin
            check("b2b_spacing1", 128'(acc[1] - acc[0]), 128'(NR0 + 2));
            check("b2b_spacing2", 128'(acc[2] - acc[1]), 128'(NR0 + 2));
        end else begin
            check("b2b_accepts", 128'(nacc), 128'(3));
        end

        // Reset in the middle of a transaction, then a clean block afterwards.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_block[0] = rand128();
        @(negedge clk);
        in_valid[0] = 1'b0;
        cyc = 0;
        while (key_idx[0] != 4'd5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_k5", 128'(key_idx[0]), 128'(5));
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        ct = rand128();
        transact(0, ct, 1'b0, 1'b1, got);
        check("after_abort", got, ref_decrypt(0, ct));

        // in_valid toggling with random data while busy must not disturb the result.
        ct = rand128();
        transact(1, ct, 1'b0, 1'b0, got);
        check("quiet_run", got, ref_decrypt(1, ct));
        transact(1, ct, 1'b1, 1'b1, got);
        check("noisy_run", got, ref_decrypt(1, ct));

        // Random blocks on both key sizes.
        for (int i = 0; i < 6; i++) begin
            ct = rand128();
            transact(i % 2, ct, i >= 3, 1'b0, got);
            check("random_block", got, ref_decrypt(i % 2, ct));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
